// File: rtl/cross_bar_mux_arbiter.sv
// Packet-granular round-robin merge of CHANNEL_NO AXI-Stream inputs onto one output.
// The m-side is driven from a 2-entry skid slice, so m_axis_tready never reaches s_axis_tready combinationally.
module cross_bar_mux_arbiter #(
  parameter int MSEL_WIDTH = 2,
  parameter int CHANNEL_NO = 2**MSEL_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata [CHANNEL_NO],
  input  logic [CHANNEL_NO-1:0] s_axis_tvalid,
  input  logic [CHANNEL_NO-1:0] s_axis_tlast,
  output logic [CHANNEL_NO-1:0] s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [MSEL_WIDTH-1:0] m_axis_tid,
  input  logic                  m_axis_tready
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACTIVE = 2'b01;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic [MSEL_WIDTH-1:0] tid;
  } beat_t;

  logic [1:0]            state_q, state_d;
  logic [MSEL_WIDTH-1:0] grant_q, grant_d;
  logic [MSEL_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [MSEL_WIDTH-1:0] rr_pick, rr_idx;
  logic                  rr_any;
  logic                  slice_ready, accept;
  beat_t                 in_beat;
  beat_t                 main_q, main_d, skid_q, skid_d;
  logic                  main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;

  assign slice_ready = ~skid_vld_q;
  assign in_beat     = '{data: s_axis_tdata[grant_q], last: s_axis_tlast[grant_q], tid: grant_q};

  // Scan from the farthest offset down so the nearest valid channel after last_grant wins.
  always_comb begin
    rr_pick = last_grant_q;
    rr_idx  = last_grant_q;
    rr_any  = |s_axis_tvalid;
    for (int i = CHANNEL_NO; i >= 1; i--) begin
      rr_idx = last_grant_q + MSEL_WIDTH'(i);
      if (s_axis_tvalid[rr_idx]) rr_pick = rr_idx;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    s_axis_tready = '0;
    accept        = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_any) begin
          grant_d = rr_pick;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        s_axis_tready[grant_q] = slice_ready;
        accept = s_axis_tvalid[grant_q] & slice_ready;
        if (accept && s_axis_tlast[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Skid slice: a beat arriving while main is stalled parks in skid; skid refills main first.
  always_comb begin
    main_vld_d = main_vld_q;
    main_d     = main_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (!main_vld_q || m_axis_tready) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = in_beat;
      end
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_d     = in_beat;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= MSEL_WIDTH'(CHANNEL_NO - 1);
      main_q       <= '0;
      skid_q       <= '0;
      main_vld_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_vld_q   <= main_vld_d;
      skid_vld_q   <= skid_vld_d;
    end
  end

  assign m_axis_tvalid = main_vld_q;
  assign m_axis_tdata  = main_q.data;
  assign m_axis_tlast  = main_q.last;
  assign m_axis_tid    = main_q.tid;

endmodule

// File: tb/tb_cross_bar_mux_arbiter.sv
// Directed bench for cross_bar_mux_arbiter: per-channel source queues feed the DUT,
// an m-side log records accepted beats, and each test task checks the log against hand-computed beats.
module tb_cross_bar_mux_arbiter;
  localparam int MW = 2;
  localparam int CN = 4;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] s_axis_tdata [CN];
  logic [CN-1:0] s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [MW-1:0] m_axis_tid;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } sbeat_t;

  sbeat_t        srcq [CN][$];
  logic [DW-1:0] lg_d[$];
  logic [MW-1:0] lg_tid[$];
  logic          lg_last[$];
  int            lg_cyc[$];

  int cyc = 0, checks = 0, errors = 0;
  bit drv_en = 0, rnd_rdy = 0, rdy_val = 1, multi_rdy = 0;

  cross_bar_mux_arbiter #(.MSEL_WIDTH(MW), .CHANNEL_NO(CN), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .m_axis_tready(m_axis_tready)
  );

  always #5 aclk = ~aclk;

  // Sample handshakes at negedge, advance sources and drive inputs 1ns after posedge.
  initial begin : drv
    logic [CN-1:0] hs;
    forever begin
      @(negedge aclk);
      hs = s_axis_tvalid & s_axis_tready;
      if (m_axis_tvalid && m_axis_tready) begin
        lg_d.push_back(m_axis_tdata);
        lg_tid.push_back(m_axis_tid);
        lg_last.push_back(m_axis_tlast);
        lg_cyc.push_back(cyc);
      end
      if (!$onehot0(s_axis_tready)) multi_rdy = 1;
      @(posedge aclk);
      #1;
      cyc++;
      if (drv_en) begin
        for (int c = 0; c < CN; c++) begin
          if (hs[c] && srcq[c].size() > 0) void'(srcq[c].pop_front());
          s_axis_tvalid[c] = srcq[c].size() > 0;
          s_axis_tdata[c]  = (srcq[c].size() > 0) ? srcq[c][0].d : '0;
          s_axis_tlast[c]  = (srcq[c].size() > 0) ? srcq[c][0].l : 1'b0;
        end
        m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'(rdy_val);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic nclk();
    @(negedge aclk);
    #1;
  endtask

  task automatic clear_log();
    lg_d.delete(); lg_tid.delete(); lg_last.delete(); lg_cyc.delete();
  endtask

  task automatic push_pkt(int ch, logic [DW-1:0] base, int n);
    sbeat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = base + DW'(i);
      b.l = (i == n - 1);
      srcq[ch].push_back(b);
    end
  endtask

  task automatic wait_log(int n, int limit);
    int t = 0;
    while (lg_d.size() < n && t < limit) begin
      nclk();
      t++;
    end
  endtask

  task automatic do_reset();
    nclk();
    areset = 1;
    for (int c = 0; c < CN; c++) srcq[c].delete();
    clear_log();
    nclk();
    nclk();
    areset = 0;
    nclk();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge aclk);
      #2;
      s_axis_tvalid = CN'($urandom);
      s_axis_tlast  = CN'($urandom);
      m_axis_tready = 1'($urandom_range(0, 1));
      for (int c = 0; c < CN; c++) s_axis_tdata[c] = $urandom;
      nclk();
      checks++;
      if (m_axis_tvalid !== 1'b0) begin
        errors++; $display("FAIL reset_mvalid: got %0b want 0", m_axis_tvalid);
      end
      checks++;
      if (s_axis_tready !== 4'b0000) begin
        errors++; $display("FAIL reset_sready: got %b want 0000", s_axis_tready);
      end
    end
    checks++;
    if ({m_axis_tdata, m_axis_tlast, m_axis_tid} !== '0) begin
      errors++; $display("FAIL reset_mfields: data=%h last=%0b tid=%0d want 0", m_axis_tdata, m_axis_tlast, m_axis_tid);
    end
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    for (int c = 0; c < CN; c++) s_axis_tdata[c] = '0;
    m_axis_tready = 1'b1;
    areset = 0;
    drv_en = 1;
    for (int k = 0; k < 3; k++) begin
      nclk();
      checks++;
      if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0000) begin
        errors++; $display("FAIL post_reset_idle: mvalid=%0b sready=%b want 0/0000", m_axis_tvalid, s_axis_tready);
      end
    end
  endtask

  task automatic test_single_packet();
    int c0;
    clear_log();
    nclk();
    c0 = cyc;
    push_pkt(2, 32'hA0, 3);
    wait_log(3, 40);
    checks++;
    if (lg_d.size() != 3) begin
      errors++; $display("FAIL single_count: got %0d beats want 3", lg_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (lg_d[i] !== 32'hA0 + DW'(i) || lg_tid[i] !== 2'd2 || lg_last[i] !== (i == 2)) begin
          errors++; $display("FAIL single_beat%0d: data=%h tid=%0d last=%0b want %h/2/%0b",
                             i, lg_d[i], lg_tid[i], lg_last[i], 32'hA0 + DW'(i), (i == 2));
        end
      end
      checks++;
      if (lg_cyc[0] != c0 + 3 || lg_cyc[2] != c0 + 5) begin
        errors++; $display("FAIL single_latency: first=%0d last=%0d want %0d/%0d", lg_cyc[0], lg_cyc[2], c0 + 3, c0 + 5);
      end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < CN; c++) push_pkt(c, 32'hC0 + DW'(c), 1);
    wait_log(8, 60);
    checks++;
    if (lg_d.size() != 8) begin
      errors++; $display("FAIL fair_count: got %0d beats want 8", lg_d.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (lg_tid[i] !== MW'(i % 4) || lg_d[i] !== 32'hC0 + DW'(i % 4) || lg_last[i] !== 1'b1) begin
          errors++; $display("FAIL fair_beat%0d: tid=%0d data=%h last=%0b want %0d/%h/1",
                             i, lg_tid[i], lg_d[i], lg_last[i], i % 4, 32'hC0 + DW'(i % 4));
        end
        if (i > 0) begin
          checks++;
          if (lg_cyc[i] - lg_cyc[i-1] != 2) begin
            errors++; $display("FAIL fair_bubble%0d: gap=%0d want 2", i, lg_cyc[i] - lg_cyc[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_no_interleave();
    int  t;
    bit  bad;
    logic [DW-1:0] ed;
    logic [MW-1:0] et;
    do_reset();
    push_pkt(1, 32'h10, 4);
    t = 0;
    while (srcq[1].size() > 2 && t < 50) begin nclk(); t++; end
    push_pkt(0, 32'h20, 2);
    bad = 0;
    t = 0;
    while (srcq[1].size() > 0 && t < 50) begin
      if (s_axis_tready[0]) bad = 1;
      nclk();
      t++;
    end
    checks++;
    if (bad || srcq[1].size() != 0) begin
      errors++; $display("FAIL noint_ch0_ready: ch0 tready seen=%0b ch1 left=%0d want 0/0", bad, srcq[1].size());
    end
    wait_log(6, 60);
    checks++;
    if (lg_d.size() != 6) begin
      errors++; $display("FAIL noint_count: got %0d beats want 6", lg_d.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        ed = (i < 4) ? 32'h10 + DW'(i) : 32'h20 + DW'(i - 4);
        et = (i < 4) ? 2'd1 : 2'd0;
        checks++;
        if (lg_d[i] !== ed || lg_tid[i] !== et || lg_last[i] !== (i == 3 || i == 5)) begin
          errors++; $display("FAIL noint_beat%0d: data=%h tid=%0d last=%0b want %h/%0d/%0b",
                             i, lg_d[i], lg_tid[i], lg_last[i], ed, et, (i == 3 || i == 5));
        end
      end
      checks++;
      if (lg_cyc[4] - lg_cyc[3] != 2 || lg_cyc[5] - lg_cyc[4] != 1) begin
        errors++; $display("FAIL noint_gap: gaps=%0d,%0d want 2,1", lg_cyc[4] - lg_cyc[3], lg_cyc[5] - lg_cyc[4]);
      end
    end
  endtask

  task automatic test_backpressure();
    int l0, q0;
    logic [DW-1:0] d0, ed;
    logic [MW-1:0] et;
    clear_log();
    push_pkt(2, 32'h50, 8);
    wait_log(2, 40);
    rdy_val = 0;
    nclk();
    l0 = lg_d.size();
    q0 = srcq[2].size();
    d0 = m_axis_tdata;
    repeat (4) nclk();
    checks++;
    if (lg_d.size() != l0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== d0) begin
      errors++; $display("FAIL bp_hold: beats=%0d valid=%0b data=%h want %0d/1/%h", lg_d.size(), m_axis_tvalid, m_axis_tdata, l0, d0);
    end
    checks++;
    if (q0 - srcq[2].size() > 2 || s_axis_tready[2] !== 1'b0) begin
      errors++; $display("FAIL bp_sready: accepted=%0d tready=%0b want <=2/0", q0 - srcq[2].size(), s_axis_tready[2]);
    end
    rdy_val = 1;
    wait_log(8, 60);
    checks++;
    if (lg_d.size() != 8) begin
      errors++; $display("FAIL bp_count: got %0d beats want 8", lg_d.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (lg_d[i] !== 32'h50 + DW'(i) || lg_tid[i] !== 2'd2 || lg_last[i] !== (i == 7)) begin
          errors++; $display("FAIL bp_beat%0d: data=%h tid=%0d last=%0b want %h/2/%0b",
                             i, lg_d[i], lg_tid[i], lg_last[i], 32'h50 + DW'(i), (i == 7));
        end
      end
    end
    // Random ready: last grant was ch2, so ch3 must win over ch1.
    clear_log();
    rnd_rdy = 1;
    push_pkt(1, 32'h60, 10);
    push_pkt(3, 32'h70, 3);
    wait_log(13, 400);
    rnd_rdy = 0;
    repeat (5) nclk();
    checks++;
    if (lg_d.size() != 13) begin
      errors++; $display("FAIL rnd_count: got %0d beats want 13", lg_d.size());
    end else begin
      for (int i = 0; i < 13; i++) begin
        ed = (i < 3) ? 32'h70 + DW'(i) : 32'h60 + DW'(i - 3);
        et = (i < 3) ? 2'd3 : 2'd1;
        checks++;
        if (lg_d[i] !== ed || lg_tid[i] !== et || lg_last[i] !== (i == 2 || i == 12)) begin
          errors++; $display("FAIL rnd_beat%0d: data=%h tid=%0d last=%0b want %h/%0d/%0b",
                             i, lg_d[i], lg_tid[i], lg_last[i], ed, et, (i == 2 || i == 12));
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int t;
    logic [DW-1:0] ed;
    logic [MW-1:0] et;
    do_reset();
    push_pkt(3, 32'h80, 4);
    t = 0;
    while (!(m_axis_tvalid && m_axis_tdata == 32'h81) && t < 40) begin nclk(); t++; end
    checks++;
    if (!(m_axis_tvalid && m_axis_tdata == 32'h81)) begin
      errors++; $display("FAIL rstmid_reach: never saw beat 2, data=%h want 00000081", m_axis_tdata);
    end
    areset = 1;
    for (int c = 0; c < CN; c++) srcq[c].delete();
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 4'b0000 || {m_axis_tdata, m_axis_tlast, m_axis_tid} !== '0) begin
      errors++; $display("FAIL rstmid_clear: valid=%0b sready=%b data=%h want 0/0000/0", m_axis_tvalid, s_axis_tready, m_axis_tdata);
    end
    clear_log();
    nclk();
    nclk();
    areset = 0;
    nclk();
    push_pkt(0, 32'h90, 2);
    push_pkt(3, 32'hB0, 2);
    wait_log(4, 40);
    repeat (10) nclk();
    checks++;
    if (lg_d.size() != 4) begin
      errors++; $display("FAIL rstmid_count: got %0d beats want 4", lg_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        ed = (i < 2) ? 32'h90 + DW'(i) : 32'hB0 + DW'(i - 2);
        et = (i < 2) ? 2'd0 : 2'd3;
        checks++;
        if (lg_d[i] !== ed || lg_tid[i] !== et || lg_last[i] !== (i == 1 || i == 3)) begin
          errors++; $display("FAIL rstmid_beat%0d: data=%h tid=%0d last=%0b want %h/%0d/%0b",
                             i, lg_d[i], lg_tid[i], lg_last[i], ed, et, (i == 1 || i == 3));
        end
      end
    end
  endtask

  initial begin
    areset        = 1;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b0;
    for (int c = 0; c < CN; c++) s_axis_tdata[c] = '0;
    test_reset();
    test_single_packet();
    test_fairness();
    test_no_interleave();
    test_backpressure();
    test_reset_mid_packet();
    checks++;
    if (multi_rdy) begin
      errors++; $display("FAIL onehot_ready: more than one s_axis_tready seen high=1 want 0");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
